mips_data_mem: RTL and testbench



---
 rtl/mips_data_mem.sv | 125 ++++++++++++
 tb/tb_mips_data_mem.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_mem.sv
// mips_data_mem: data-memory responder for the core's data port.
// Serves word-addressed loads and byte-masked stores from an internal word
// array. Completion is signalled LATENCY cycles after a request is accepted.
// Addresses outside the mapped data segment complete with an exception.
//
// Ports:
//   clk          - clock, all state updates on posedge
//   rst          - synchronous active-high reset
//   mem_req      - request valid (sampled only in IDLE)
//   mem_addr     - word address (byte address [31:2])
//   mem_write_en - byte-lane write mask, 4'b0000 = load
//   mem_data_in  - store data
//   mem_data_out - load data, non-zero only during the response cycle
//   mem_ready    - one-cycle completion strobe
//   mem_excpt    - address error, valid only with mem_ready
//   busy         - high whenever a transaction is in flight
module mips_data_mem #(
    parameter logic [31:0] DATA_START  = 32'h10000000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic [29:0] mem_addr,
    input  logic [3:0]  mem_write_en,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        mem_ready,
    output logic        mem_excpt,
    output logic        busy
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] BASE_W   = DATA_START[31:2];
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [29:0] addr_q;
    logic [3:0]  we_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic        ready_q;
    logic        excpt_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    // In IDLE the live inputs drive the decode (needed when LATENCY==1 goes
    // straight to RESP); afterwards only the latched copies are used.
    logic [29:0]   addr_d;
    logic [3:0]    we_d;
    logic [29:0]   idx_d;
    logic          in_range_d;
    logic [AW-1:0] widx_d;
    logic          go_resp_d;

    assign addr_d     = (state_q == IDLE) ? mem_addr : addr_q;
    assign we_d       = (state_q == IDLE) ? mem_write_en : we_q;
    // Addresses below the base wrap to a huge index and fail the range test.
    assign idx_d      = addr_d - BASE_W;
    assign in_range_d = (idx_d < DEPTH_W);
    assign widx_d     = idx_d[AW-1:0];

    assign go_resp_d  = ((state_q == IDLE) && mem_req && (LATENCY == 1)) ||
                        ((state_q == WAIT) && (cnt_q == 4'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            excpt_q <= 1'b0;
        end else begin
            // Response outputs default low; only the entry into RESP sets them.
            ready_q <= 1'b0;
            excpt_q <= 1'b0;
            data_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        addr_q  <= mem_addr;
                        we_q    <= mem_write_en;
                        wdata_q <= mem_data_in;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (go_resp_d) begin
                ready_q <= 1'b1;
                excpt_q <= ~in_range_d;
                if (in_range_d && (we_d == 4'b0000)) data_q <= mem_q[widx_d];
            end
        end
    end

    // Store commits at the edge that ends RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == RESP) && in_range_d) begin
            for (int i = 0; i < 4; i++) begin
                if (we_q[i]) mem_q[widx_d][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign mem_data_out = data_q;
    assign mem_ready    = ready_q;
    assign mem_excpt    = excpt_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mips_data_mem.sv
// Bench for mips_data_mem: two instances (LATENCY=2 and LATENCY=1) driven by
// directed vectors, checked every cycle against a transaction-level model and
// by literal expectations on selected responses.
module tb_mips_data_mem;

    logic              clk;
    logic              rst;
    logic [1:0]        req;
    logic [1:0][29:0]  addr;
    logic [1:0][3:0]   we;
    logic [1:0][31:0]  din;
    logic [1:0][31:0]  dout;
    logic [1:0]        rdy;
    logic [1:0]        exc;
    logic [1:0]        bsy;

    int checks   = 0;
    int failures = 0;

    mips_data_mem #(.DATA_START(32'h10000000), .DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .mem_req(req[0]), .mem_addr(addr[0]),
        .mem_write_en(we[0]), .mem_data_in(din[0]), .mem_data_out(dout[0]),
        .mem_ready(rdy[0]), .mem_excpt(exc[0]), .busy(bsy[0]));

    mips_data_mem #(.DATA_START(32'h10000000), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_req(req[1]), .mem_addr(addr[1]),
        .mem_write_en(we[1]), .mem_data_in(din[1]), .mem_data_out(dout[1]),
        .mem_ready(rdy[1]), .mem_excpt(exc[1]), .busy(bsy[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] mm [2][1024];
    logic        kn [2][1024];
    logic        pend [2];
    int          rcyc [2];
    logic [29:0] ma [2];
    logic [3:0]  mw [2];
    logic [31:0] md [2];
    int          cyc   = 0;
    logic        armed = 1'b0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0;
            for (int j = 0; j < 1024; j++) kn[k][j] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) pend[k] = 1'b0;
                else if (pend[k] && cyc == rcyc[k]) begin
                    logic [29:0] ix;
                    ix = ma[k] - 30'h04000000;
                    if (ix < 30'd1024 && mw[k] != 4'b0) begin
                        for (int b = 0; b < 4; b++)
                            if (mw[k][b]) mm[k][ix][8*b +: 8] = md[k][8*b +: 8];
                        if (mw[k] == 4'hF) kn[k][ix] = 1'b1;
                    end
                    pend[k] = 1'b0;
                end else if (!pend[k] && req[k]) begin
                    pend[k] = 1'b1;
                    rcyc[k] = cyc + lat_of(k);
                    ma[k] = addr[k]; mw[k] = we[k]; md[k] = din[k];
                end
            end
            if (rst) armed = 1'b1;
            cyc++;
            @(negedge clk);
            if (armed) begin
                for (int k = 0; k < 2; k++) begin
                    logic        er, ee, dk;
                    logic [31:0] ed;
                    logic [29:0] ix;
                    ix = ma[k] - 30'h04000000;
                    er = pend[k] && (cyc == rcyc[k]);
                    ee = 1'b0; ed = 32'h0; dk = 1'b1;
                    if (er) begin
                        if (ix >= 30'd1024) ee = 1'b1;
                        else if (mw[k] == 4'b0) begin
                            ed = mm[k][ix];
                            dk = kn[k][ix];
                        end
                    end
                    chk($sformatf("cmp_busy%0d", k),  {31'b0, bsy[k]}, {31'b0, pend[k]});
                    chk($sformatf("cmp_ready%0d", k), {31'b0, rdy[k]}, {31'b0, er});
                    chk($sformatf("cmp_excpt%0d", k), {31'b0, exc[k]}, {31'b0, ee});
                    if (dk) chk($sformatf("cmp_data%0d", k), dout[k], ed);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // One request; a_after replaces the address once the request is accepted.
    task automatic xact(input int k, input logic [29:0] a, input logic [29:0] a_after,
                        input logic [3:0] w, input logic [31:0] d,
                        output logic [31:0] rd, output logic rx, output int lat);
        @(negedge clk);
        req[k] = 1'b1; addr[k] = a; we[k] = w; din[k] = d;
        @(negedge clk);
        req[k] = 1'b0; addr[k] = a_after; we[k] = 4'b0; din[k] = 32'h0;
        lat = 1;
        while (!rdy[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("xact_done", {31'b0, rdy[k]}, 32'd1);
        rd = dout[k];
        rx = exc[k];
    endtask

    logic [31:0] rd;
    logic        rx;
    int          lat;

    initial begin
        rst = 1'b1; req = '0; addr = '0; we = '0; din = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'b0, bsy[0]}, 32'd0);
        chk("rst_ready", {31'b0, rdy[0]}, 32'd0);
        chk("rst_excpt", {31'b0, exc[0]}, 32'd0);
        chk("rst_data",  dout[0], 32'h0);
        chk("rst_busy1", {31'b0, bsy[1]}, 32'd0);
        rst = 1'b0;

        // Timing, LATENCY=2: accepted at end of cycle 0.
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 30'h04000000; we[0] = 4'b0;
        chk("t0_ready", {31'b0, rdy[0]}, 32'd0);
        chk("t0_busy",  {31'b0, bsy[0]}, 32'd0);
        @(negedge clk); req[0] = 1'b0;
        chk("t1_ready", {31'b0, rdy[0]}, 32'd0);
        chk("t1_busy",  {31'b0, bsy[0]}, 32'd1);
        @(negedge clk);
        chk("t2_ready", {31'b0, rdy[0]}, 32'd1);
        chk("t2_busy",  {31'b0, bsy[0]}, 32'd1);
        @(negedge clk);
        chk("t3_ready", {31'b0, rdy[0]}, 32'd0);
        chk("t3_busy",  {31'b0, bsy[0]}, 32'd0);

        // Preload words used later.
        xact(0, 30'h04000000, 30'h0, 4'hF, 32'h00C0FFEE, rd, rx, lat);
        chk("store_lat", lat, 32'd2);
        chk("store_data_zero", rd, 32'h0);
        xact(0, 30'h04000003, 30'h0, 4'hF, 32'h33333333, rd, rx, lat);
        xact(0, 30'h04000007, 30'h0, 4'hF, 32'h77777777, rd, rx, lat);
        xact(0, 30'h04000008, 30'h0, 4'hF, 32'h88888888, rd, rx, lat);
        xact(0, 30'h040003FF, 30'h0, 4'hF, 32'h3FF3FF00, rd, rx, lat);

        // Byte-lane stores then load.
        xact(0, 30'h04000005, 30'h0, 4'hF, 32'hDEADBEEF, rd, rx, lat);
        xact(0, 30'h04000005, 30'h0, 4'h1, 32'h00000012, rd, rx, lat);
        xact(0, 30'h04000005, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("lane_data", rd, 32'hDEADBE12);
        chk("lane_excpt", {31'b0, rx}, 32'd0);
        xact(0, 30'h04000005, 30'h0, 4'h6, 32'h00ABCD00, rd, rx, lat);
        xact(0, 30'h04000005, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("lane_mid", rd, 32'hDEABCD12);

        // Range boundaries.
        xact(0, 30'h040003FF, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("top_excpt", {31'b0, rx}, 32'd0);
        chk("top_data", rd, 32'h3FF3FF00);
        xact(0, 30'h04000400, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("past_excpt", {31'b0, rx}, 32'd1);
        chk("past_data", rd, 32'h0);
        xact(0, 30'h03FFFFFF, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("below_excpt", {31'b0, rx}, 32'd1);
        xact(0, 30'h04000400, 30'h0, 4'hF, 32'hFFFFFFFF, rd, rx, lat);
        chk("oob_store_excpt", {31'b0, rx}, 32'd1);
        xact(0, 30'h04000000, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("word0_intact", rd, 32'h00C0FFEE);

        // Reset during WAIT abandons the store.
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 30'h04000003; we[0] = 4'hF; din[0] = 32'h11111111;
        @(negedge clk);
        req[0] = 1'b0; we[0] = 4'h0; rst = 1'b1;
        chk("rw_busy_wait", {31'b0, bsy[0]}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rw_busy_after", {31'b0, bsy[0]}, 32'd0);
        chk("rw_ready_after", {31'b0, rdy[0]}, 32'd0);
        @(negedge clk);
        chk("rw_ready_late", {31'b0, rdy[0]}, 32'd0);
        xact(0, 30'h04000003, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("rw_word3", rd, 32'h33333333);

        // Address change after acceptance is ignored.
        xact(0, 30'h04000007, 30'h04000008, 4'h0, 32'h0, rd, rx, lat);
        chk("latched_addr", rd, 32'h77777777);

        // LATENCY=1 instance.
        xact(1, 30'h04000002, 30'h0, 4'hF, 32'hA5A50001, rd, rx, lat);
        chk("l1_store_lat", lat, 32'd1);
        xact(1, 30'h04000002, 30'h0, 4'h0, 32'h0, rd, rx, lat);
        chk("l1_load_lat", lat, 32'd1);
        chk("l1_load_data", rd, 32'hA5A50001);

        // Back-to-back with mem_req held high on both instances.
        begin
            int cnt0, cnt1, last0, last1;
            cnt0 = 0; cnt1 = 0; last0 = -1; last1 = -1;
            @(negedge clk);
            req = 2'b11;
            addr[0] = 30'h04000007; we[0] = 4'h0;
            addr[1] = 30'h04000002; we[1] = 4'h0;
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (rdy[0]) begin
                    if (last0 >= 0) chk("b2b_gap0", i - last0, 32'd3);
                    last0 = i; cnt0++;
                end
                if (rdy[1]) begin
                    if (last1 >= 0) chk("b2b_gap1", i - last1, 32'd2);
                    last1 = i; cnt1++;
                end
            end
            req = 2'b00;
            chk("b2b_count0", cnt0, 32'd4);
            chk("b2b_count1", cnt1, 32'd6);
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
